// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seven_seg_pkg;
  localparam int BCD_W              = 4;
  localparam int DEFAULT_NUM_DIGITS = 4;
  // Widest supported display is 8 digits; slice to NUM_DIGITS where used.
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Width of the digit index register for an n-digit display.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seven_seg_tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 while enabled and flags the first
// (slot_start) and last (slot_end) cycle of every digit slot.
module seven_seg_tick_gen #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic slot_start,
  output logic slot_end
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Free-running slot counter, held at zero while the display is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_start = enable && (cnt == '0);
  assign slot_end   = enable && (cnt == TERM);
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds the displayed (active) value plus one pending value; the pending
// value is promoted only at a frame boundary so a number never tears.
//
// Load handshake: a transfer happens on a clock edge where load_valid and
// load_ready are both 1. load_ready is 1 exactly when the pending slot is
// empty; a source seeing load_ready=0 must hold load_valid and its data.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int PRESCALE      = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]       load_dp,
  output logic [BCD_W-1:0]            digit_code,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       anode_n,
  output logic                        frame_tick
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic                        slot_start;
  logic                        slot_end;
  logic [IW-1:0]               idx;
  logic [BCD_W*NUM_DIGITS-1:0] active_val;
  logic [BCD_W*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]       active_dp;
  logic [NUM_DIGITS-1:0]       pend_dp;
  logic                        pend_full;
  logic [NUM_DIGITS-1:0]       blank_mask;
  logic [NUM_DIGITS-1:0]       one_hot;
  logic                        upper_zero;
  logic                        last_digit;
  logic                        frame_end;
  logic                        accept;
  logic                        cur_lit;
  logic [BCD_W-1:0]            cur_code;

  seven_seg_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .slot_start (slot_start),
    .slot_end   (slot_end)
  );

  assign last_digit = (idx == LAST_IDX);
  assign frame_end  = slot_end && last_digit;
  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;
  assign one_hot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  assign cur_code   = active_val[BCD_W*int'(idx) +: BCD_W];
  // The guard cycle (slot_start) keeps all anodes off to avoid ghosting.
  assign cur_lit    = enable && !slot_start && !blank_mask[idx];

  // Leading-zero mask: digit i>0 is blank when it and every higher nibble is 0.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (active_val[BCD_W*i +: BCD_W] == '0);
      blank_mask[i] = (BLANK_LEADING != 0) && upper_zero;
    end
  end

  // Digit index: advances at each slot end, restarts at 0 when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (!enable) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  // Pending/active value registers and the load handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_val <= '0;
      active_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
    end else begin
      if (pend_full && (frame_end || !enable)) begin
        active_val <= pend_val;
        active_dp  <= pend_dp;
        pend_full  <= 1'b0;
      end
      if (accept) begin
        pend_val  <= load_value;
        pend_dp   <= load_dp;
        pend_full <= 1'b1;
      end
    end
  end

  // Registered display outputs for the current slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n    <= ANODES_OFF[NUM_DIGITS-1:0];
      digit_code <= '0;
      dp_out     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      anode_n    <= cur_lit ? ~one_hot : ANODES_OFF[NUM_DIGITS-1:0];
      digit_code <= enable ? cur_code : active_val[BCD_W-1:0];
      dp_out     <= cur_lit && active_dp[idx];
      frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: randomized and directed loads, a cycle-level
// reference model derived from time-since-enable arithmetic, and a monitor
// that pops expected output vectors and compares them every cycle.
module tb_seven_seg_scanner;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BL = 1;
  localparam int FRAME = N * P;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          load_valid;
  logic          load_ready;
  logic [4*N-1:0] load_value;
  logic [N-1:0]  load_dp;
  logic [3:0]    digit_code;
  logic          dp_out;
  logic [N-1:0]  anode_n;
  logic          frame_tick;

  // Expected vector: {anode_n, digit_code, dp_out, frame_tick, load_ready}
  logic [10:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  bit          m_pf;

  seven_seg_scanner #(
    .NUM_DIGITS    (N),
    .PRESCALE      (P),
    .BLANK_LEADING (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_dp    (load_dp),
    .digit_code (digit_code),
    .dp_out     (dp_out),
    .anode_n    (anode_n),
    .frame_tick (frame_tick)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: from the state before each edge, predict the
  // registered outputs after it.
  initial begin
    logic [3:0] a, code;
    logic dp, ft, lit, blanked, xfer, acc;
    int phase, digit;
    m_t = 0; m_act = 0; m_pend = 0; m_adp = 0; m_pdp = 0; m_pf = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = 0; m_act = 0; m_pend = 0; m_adp = 0; m_pdp = 0; m_pf = 0;
        exp_q.delete();
      end else begin
        a = 4'hF; dp = 1'b0; ft = 1'b0;
        if (enable) begin
          phase   = int'(m_t % P);
          digit   = int'((m_t / P) % N);
          code    = 4'((m_act >> (4 * digit)) & 16'hF);
          blanked = (BL != 0) && (digit > 0) && ((m_act >> (4 * digit)) == 16'h0);
          lit     = (phase != 0) && !blanked;
          if (lit) a[digit] = 1'b0;
          dp = lit && m_adp[digit];
          ft = (phase == P - 1) && (digit == N - 1);
        end else begin
          code = m_act[3:0];
        end
        xfer = m_pf && (ft || !enable);
        acc  = load_valid && !m_pf;
        if (xfer) begin m_act = m_pend; m_adp = m_pdp; m_pf = 0; end
        if (acc)  begin m_pend = load_value; m_pdp = load_dp; m_pf = 1; end
        m_t = enable ? m_t + 1 : 0;
        exp_q.push_back({a, code, dp, ft, !m_pf});
      end
    end
  end

  // Monitor: compare every registered output vector on the falling edge.
  initial begin
    logic [10:0] e, g;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {anode_n, digit_code, dp_out, frame_tick, load_ready};
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got anode_n=%b code=%h dp=%b ft=%b ready=%b, expected anode_n=%b code=%h dp=%b ft=%b ready=%b",
                   $time, g[10:7], g[6:3], g[2], g[1], g[0], e[10:7], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // Direct check of asynchronous reset values.
  task automatic check_reset(input string name);
    logic [10:0] g;
    g = {anode_n, digit_code, dp_out, frame_tick, load_ready};
    n_cmp++;
    if (g !== 11'b1111_0000_0_0_1) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, g, 11'b1111_0000_0_0_1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a load and hold it until the handshake completes.
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    int  waited;
    bit  r;
    @(posedge clk); #1;
    load_valid = 1'b1; load_value = v; load_dp = dp;
    waited = 0;
    forever begin
      @(negedge clk); r = load_ready;
      @(posedge clk);
      if (r) break;
      waited++;
      if (waited > 200) begin
        n_cmp++; n_err++;
        $display("FAIL load_timeout: got load_ready=0 for %0d cycles, expected acceptance", waited);
        break;
      end
    end
    #1 load_valid = 1'b0;
  endtask

  // Present a load so that it is sampled in a frame-boundary cycle.
  task automatic boundary_load(input logic [15:0] v);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(load_ready && m_pf == 0 && (m_t % FRAME) == FRAME - 1)) begin
      @(negedge clk);
      waited++;
      if (waited > 200) begin
        n_cmp++; n_err++;
        $display("FAIL boundary_wait: got no boundary in %0d cycles, expected one", waited);
        break;
      end
    end
    load_valid = 1'b1; load_value = v; load_dp = 4'b0000;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [31:0] r;
    logic [15:0] v;
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_value = '0; load_dp = '0;
    #12;
    check_reset("reset_values");
    idle(3);
    @(negedge clk); rst_n = 1'b1;

    // Load while dark: one-cycle ready drop, then active immediately.
    do_load(16'h1234, 4'b0000);
    idle(2);
    enable = 1'b1;
    idle(3 * FRAME);

    do_load(16'h0007, 4'b0000);  idle(2 * FRAME + 4);
    do_load(16'h0000, 4'b0000);  idle(2 * FRAME + 4);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);  idle(3 * FRAME);
    boundary_load(16'h4321);     idle(3 * FRAME);
    do_load(16'h5A00, 4'b0100);  idle(3 * FRAME);

    // Disable mid-slot, load while dark, re-enable.
    idle(6);
    enable = 1'b0;
    do_load(16'h9876, 4'b1001);
    idle(4);
    enable = 1'b1;
    idle(2 * FRAME);

    // Reset mid-frame with a pending load outstanding.
    idle(5);
    do_load(16'h3333, 4'b1111);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid_frame");
    idle(2);
    check_reset("reset_held");
    @(negedge clk); rst_n = 1'b1;
    idle(3 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      v = r[15:0] >> (4 * $urandom_range(0, 3));
      do_load(v, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 9) == 0) begin
        enable = ~enable;
        idle($urandom_range(1, 6));
      end
    end
    enable = 1'b1;
    idle(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
